// File: rtl/bounded_counter_gen.sv
// Bounded up/down counter over a cyclic window [S..E] mod MODULUS with a
// prescaler and WRAP / BOUNCE / ONESHOT end-of-window behaviour.
module bounded_counter_gen #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             ud,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] start_vl,
  input  logic [WIDTH-1:0] stop_vl,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             wrap,
  output logic             done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  localparam logic [1:0] M_BOUNCE  = 2'd1;
  localparam logic [1:0] M_ONESHOT = 2'd2;

  logic [WIDTH-1:0] out_q, out_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] s_c, e_c, end_v;
  logic             in_win, step_up, at_end;

  function automatic logic [WIDTH-1:0] inc_m(input logic [WIDTH-1:0] v);
    return (v == MAXV) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] dec_m(input logic [WIDTH-1:0] v);
    return (v == '0) ? MAXV : v - 1'b1;
  endfunction

  assign s_c     = (start_vl > MAXV) ? MAXV : start_vl;
  assign e_c     = (stop_vl  > MAXV) ? MAXV : stop_vl;
  // A wrapped window (S > E) covers S..MODULUS-1 then 0..E.
  assign in_win  = (s_c <= e_c) ? (out_q >= s_c && out_q <= e_c)
                                : (out_q >= s_c || out_q <= e_c);
  assign step_up = (mode == M_BOUNCE) ? ~dir_q : ~ud;
  assign end_v   = step_up ? e_c : s_c;
  assign at_end  = (out_q == end_v);

  always_comb begin
    out_d  = out_q;
    pre_d  = pre_q;
    dir_d  = dir_q;
    done_d = done_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (restart) begin
      out_d  = ud ? e_c : s_c;
      pre_d  = '0;
      done_d = 1'b0;
      dir_d  = ud;
    end else if (en) begin
      if (mode != M_BOUNCE) dir_d = ud;
      if (!(done_q && mode == M_ONESHOT)) begin
        if (pre_q != PMAX) begin
          pre_d = pre_q + 1'b1;
        end else begin
          pre_d = '0;
          if (!in_win) begin
            out_d  = step_up ? s_c : e_c;
            tick_d = 1'b1;
          end else if (at_end) begin
            if (mode == M_BOUNCE) begin
              dir_d  = ~dir_q;
              out_d  = (s_c == e_c) ? s_c : (step_up ? dec_m(e_c) : inc_m(s_c));
              tick_d = 1'b1;
              wrap_d = 1'b1;
            end else if (mode == M_ONESHOT) begin
              done_d = 1'b1;
            end else begin
              out_d  = step_up ? s_c : e_c;
              tick_d = 1'b1;
              wrap_d = 1'b1;
            end
          end else begin
            out_d  = step_up ? inc_m(out_q) : dec_m(out_q);
            tick_d = 1'b1;
          end
          // ONESHOT completes on the step that lands on the window end.
          if (mode == M_ONESHOT && tick_d && out_d == end_v) done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      pre_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      pre_q  <= pre_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

// File: tb/tb_bounded_counter_gen.sv
// Scoreboard bench: two instances (DIV=1, DIV=3) share stimulus; a window-list
// reference model pushes expectations, a monitor pops and compares each cycle.
module tb_bounded_counter_gen;
  localparam int W = 4;
  localparam int M = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, restart = 1'b0, ud = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [W-1:0] start_vl = '0, stop_vl = '0;
  logic [W-1:0] out1, out3;
  logic tick1, wrap1, done1, tick3, wrap3, done3;

  always #5 clk = ~clk;

  bounded_counter_gen #(.WIDTH(W), .MODULUS(M), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .ud(ud), .mode(mode),
    .start_vl(start_vl), .stop_vl(stop_vl), .out(out1), .tick(tick1),
    .wrap(wrap1), .done(done1));

  bounded_counter_gen #(.WIDTH(W), .MODULUS(M), .DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .ud(ud), .mode(mode),
    .start_vl(start_vl), .stop_vl(stop_vl), .out(out3), .tick(tick3),
    .wrap(wrap3), .done(done3));

  typedef struct { int out; int pre; bit dir; bit done; bit tick; bit wrap; } mst_t;
  typedef struct { int out; bit tick; bit wrap; bit done; int cyc; } exp_t;

  mst_t m1, m3;
  exp_t q1[$], q3[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;

  function automatic int clampv(int v);
    return (v >= M) ? M - 1 : v;
  endfunction

  // Walk the window from S toward E; membership is whatever that walk visits.
  function automatic bit in_win(int v, int s, int e);
    int x = s;
    for (int k = 0; k < M; k++) begin
      if (x == v) return 1'b1;
      if (x == e) return 1'b0;
      x = (x + 1) % M;
    end
    return 1'b0;
  endfunction

  function automatic mst_t model_next(mst_t s, int div, bit r, bit e_n, bit rs,
                                      bit u, int md, int sv, int ev);
    mst_t n = s;
    int S, E, endv;
    bit up;
    n.tick = 1'b0; n.wrap = 1'b0;
    if (r) begin n.out = 0; n.pre = 0; n.dir = 1'b0; n.done = 1'b0; return n; end
    S = clampv(sv); E = clampv(ev);
    if (rs) begin n.out = u ? E : S; n.pre = 0; n.done = 1'b0; n.dir = u; return n; end
    if (!e_n) return n;
    if (md != 1) n.dir = u;
    if (s.done && md == 2) return n;
    if (s.pre != div - 1) begin n.pre = s.pre + 1; return n; end
    n.pre = 0;
    up   = (md == 1) ? !s.dir : !u;
    endv = up ? E : S;
    if (!in_win(s.out, S, E)) begin
      n.out = up ? S : E; n.tick = 1'b1;
    end else if (s.out == endv) begin
      if (md == 1) begin
        n.dir = !s.dir;
        n.out = (S == E) ? S : (up ? (E + M - 1) % M : (S + 1) % M);
        n.tick = 1'b1; n.wrap = 1'b1;
      end else if (md == 2) begin
        n.done = 1'b1;
      end else begin
        n.out = up ? S : E; n.tick = 1'b1; n.wrap = 1'b1;
      end
    end else begin
      n.out = up ? (s.out + 1) % M : (s.out + M - 1) % M; n.tick = 1'b1;
    end
    if (md == 2 && n.tick && n.out == endv) n.done = 1'b1;
    return n;
  endfunction

  // Apply one cycle of inputs at the falling edge and push both expectations.
  task automatic drive(bit r, bit e_n, bit rs, bit u, int md, int sv, int ev);
    exp_t x;
    @(negedge clk);
    rst = r; en = e_n; restart = rs; ud = u; mode = md[1:0];
    start_vl = sv[W-1:0]; stop_vl = ev[W-1:0];
    cyc++;
    m1 = model_next(m1, 1, r, e_n, rs, u, md, sv, ev);
    m3 = model_next(m3, 3, r, e_n, rs, u, md, sv, ev);
    x.out = m1.out; x.tick = m1.tick; x.wrap = m1.wrap; x.done = m1.done; x.cyc = cyc;
    q1.push_back(x);
    x.out = m3.out; x.tick = m3.tick; x.wrap = m3.wrap; x.done = m3.done;
    q3.push_back(x);
  endtask

  task automatic cmp(string nm, exp_t x, logic [W-1:0] o, logic t, logic w, logic d);
    n_cmp++;
    if (o !== x.out[W-1:0] || t !== x.tick || w !== x.wrap || d !== x.done) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got out=%0d tick=%b wrap=%b done=%b exp out=%0d tick=%b wrap=%b done=%b",
               nm, x.cyc, o, t, w, d, x.out, x.tick, x.wrap, x.done);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk); #1;
      if (q1.size() > 0) begin x = q1.pop_front(); cmp("div1", x, out1, tick1, wrap1, done1); end
      if (q3.size() > 0) begin x = q3.pop_front(); cmp("div3", x, out3, tick3, wrap3, done3); end
    end
  end

  initial begin : stim
    int md, sv, ev;
    bit u;
    m1 = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    m3 = m1;
    // Reset state, then WRAP up over 2..7 starting from out=0 outside the window.
    repeat (2) drive(1, 1, 0, 0, 0, 2, 7);
    repeat (16) drive(0, 1, 0, 0, 0, 2, 7);
    // WRAP down over a wrapped window 7..9,0..2.
    drive(0, 1, 1, 1, 0, 7, 2);
    repeat (14) drive(0, 1, 0, 1, 0, 7, 2);
    // BOUNCE between 3 and 5.
    drive(0, 1, 1, 0, 1, 3, 5);
    repeat (14) drive(0, 1, 0, 0, 1, 3, 5);
    // BOUNCE with S==E holds and pulses wrap.
    drive(0, 1, 1, 1, 1, 4, 4);
    repeat (8) drive(0, 1, 0, 1, 1, 4, 4);
    // ONESHOT up 0..3, then restart.
    drive(0, 1, 1, 0, 2, 0, 3);
    repeat (20) drive(0, 1, 0, 0, 2, 0, 3);
    drive(0, 1, 1, 0, 2, 0, 3);
    repeat (4) drive(0, 1, 0, 0, 2, 0, 3);
    // start_vl above range clamps to 9.
    drive(0, 1, 1, 0, 0, 12, 3);
    repeat (12) drive(0, 1, 0, 0, 0, 12, 3);
    // Mid-run reset with en and restart high, then en low holds.
    drive(0, 1, 1, 0, 0, 2, 8);
    repeat (4) drive(0, 1, 0, 0, 0, 2, 8);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; restart = 1'b1;
    #1;
    n_cmp++;
    if (out1 !== '0 || done1 !== 1'b0 || out3 !== '0 || done3 !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst got out1=%0d done1=%b out3=%0d done3=%b exp 0/0", out1, done1, out3, done3);
    end
    // Keep the model aligned: the held reset is one pushed cycle.
    cyc++;
    m1 = model_next(m1, 1, 1, 1, 1, 0, 0, 2, 8);
    m3 = model_next(m3, 3, 1, 1, 1, 0, 0, 2, 8);
    q1.push_back('{m1.out, m1.tick, m1.wrap, m1.done, cyc});
    q3.push_back('{m3.out, m3.tick, m3.wrap, m3.done, cyc});
    drive(0, 1, 0, 0, 0, 2, 8);
    drive(0, 1, 0, 0, 0, 2, 8);
    repeat (4) drive(0, 0, 0, 0, 0, 2, 8);
    // Randomized traffic.
    md = 0; sv = 1; ev = 8; u = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) md = $urandom_range(0, 3);
      if ($urandom_range(0, 14) == 0) u = $urandom_range(0, 1);
      if ($urandom_range(0, 24) == 0) sv = $urandom_range(0, 15);
      if ($urandom_range(0, 24) == 0) ev = $urandom_range(0, 15);
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 29) == 0), u, md, sv, ev);
    end
    for (int k = 0; k < 10 && (q1.size() > 0 || q3.size() > 0); k++) @(negedge clk);
    if (q1.size() > 0 || q3.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain got %0d/%0d pending exp 0", q1.size(), q3.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bounded_counter_gen.md
BOUNDED_COUNTER_GEN -- requirements
Module: bounded_counter_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: width of out, start_vl and stop_vl.
REQ-002 The block SHALL have parameter MODULUS, default 10: count range 0..MODULUS-1, with 2 <= MODULUS <= 2^WIDTH.
REQ-003 The block SHALL have parameter DIV, default 1: number of enabled cycles per count step (DIV >= 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable; when low, the prescaler and out hold.
REQ-007 The block SHALL have port restart, input, 1 bit: synchronous reload; takes priority over en.
REQ-008 The block SHALL have port ud, input, 1 bit: direction, 0 = up, 1 = down.
REQ-009 The block SHALL have port mode, input, 2 bits: 0 = WRAP, 1 = BOUNCE, 2 = ONESHOT; 3 behaves as WRAP.
REQ-010 The block SHALL have port start_vl, input, WIDTH bits: first value of the counting window.
REQ-011 The block SHALL have port stop_vl, input, WIDTH bits: last value of the counting window.
REQ-012 The block SHALL have port out, output, WIDTH bits: registered count value.
REQ-013 The block SHALL have port tick, output, 1 bit: one-cycle pulse in the cycle after out takes a step.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a step wraps or reverses at a window end.
REQ-015 The block SHALL have port done, output, 1 bit: ONESHOT complete flag, registered.

Function
REQ-016 start_vl and stop_vl values >= MODULUS SHALL be clamped to MODULUS-1 before any use; these clamped values are S and E.
REQ-017 The window SHALL be the cyclic range from S up to E modulo MODULUS.
- If S <= E, the window is S..E.
- If S > E, the window is S..MODULUS-1 followed by 0..E.
REQ-018 The prescaler SHALL count enabled cycles from 0 to DIV-1; a step occurs on the enabled cycle where the prescaler equals DIV-1, and the prescaler then returns to 0.
REQ-019 With DIV=1, a step SHALL occur on every enabled cycle.
REQ-020 Up step: out==E gives the window end; otherwise out==MODULUS-1 gives 0; otherwise out+1.
REQ-021 Down step: out==S gives the window end; otherwise out==0 gives MODULUS-1; otherwise out-1.
REQ-022 If out lies outside the window at a step (for example after start_vl or stop_vl change), out SHALL load S when the step direction is up and E when it is down; wrap stays 0 on that step.
REQ-023 WRAP mode: the step direction SHALL be ud. At a window end, out loads S (up) or E (down) and wrap pulses.
REQ-024 BOUNCE mode: an internal dir register SHALL give the step direction; dir loads ud on restart and on every cycle in which mode is not BOUNCE.
REQ-025 BOUNCE mode, window end reached: dir inverts, out takes one step in the new direction, and wrap pulses. If S==E, out holds at S and wrap pulses on every step.
REQ-026 ONESHOT mode: at the window end (E when up, S when down), out SHALL hold and done SHALL set; while done=1, no steps and no tick occur.
REQ-027 restart SHALL load out with S if ud=0 or E if ud=1, clear the prescaler, clear done, and load dir with ud; tick and wrap stay 0 in that cycle.
REQ-028 A change of mode, ud, start_vl or stop_vl SHALL take effect at the next step; no other state is disturbed.
REQ-029 en=0 SHALL freeze out, the prescaler, dir and done.
REQ-030 tick and wrap SHALL be registered and high for exactly one cycle per qualifying step.

Reset
REQ-031 rst=1 SHALL asynchronously set out=0, prescaler=0, dir=up, done=0, tick=0 and wrap=0.
REQ-032 The first step after reset SHALL follow REQ-022 when 0 is outside the window.
REQ-033 Asserting rst mid-operation SHALL abort the count immediately, with no pulse emitted in that cycle.

Verification
REQ-034 WRAP, up, S=2, E=7, DIV=1, en=1 after reset -> out = 2,3,4,5,6,7,2...; wrap pulses on the 7->2 step.
REQ-035 WRAP, down, start_vl=7, stop_vl=2 (wrapped window), MODULUS=10, out=1 -> out = 1,0,9,8,7,2,1...; wrap pulses on the 7->2 step.
REQ-036 BOUNCE, S=3, E=5, ud=0, restart -> out = 3,4,5,4,3,4...; wrap pulses on the 5->4 and 3->4 steps.
REQ-037 ONESHOT, up, S=0, E=3, DIV=3 -> out advances every 3 cycles to 3; done=1; out holds; restart -> out=0, done=0.
REQ-038 start_vl=12 with MODULUS=10, WIDTH=4 -> clamped to S=9, and the window follows REQ-017.
REQ-039 rst pulsed while out=5, with en and restart asserted -> out=0 and done=0 immediately; en=0 for 4 cycles -> out unchanged.
